// File: rtl/settle_filter.sv
// Debounces the {x,y} pair coming from an unclocked gate network: a new pair is
// published only after it has been sampled unchanged for STABLE_CYCLES clocks.
module settle_filter #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_in,
   input  logic             y_in,
   output logic             x_out,
   output logic             y_out,
   output logic             valid,
   output logic             change_pulse,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

   logic [1:0] s1, s2, cand;
   logic [7:0] cnt;
   logic       differs, pending, commit;

   assign differs = (s2 != cand);
   assign pending = (cnt < STABLE_N);
   assign commit  = !differs && (cnt == STABLE_N - 8'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= 2'b00;
         s2           <= 2'b00;
         cand         <= 2'b00;
         cnt          <= 8'd0;
         x_out        <= 1'b0;
         y_out        <= 1'b0;
         valid        <= 1'b0;
         change_pulse <= 1'b0;
         glitch_cnt   <= '0;
      end else begin
         s1           <= {x_in, y_in};
         s2           <= s1;
         change_pulse <= 1'b0;

         // A new sample while the previous candidate is still unconfirmed
         // means that candidate was abandoned.
         if (differs) begin
            cand <= s2;
            cnt  <= 8'd1;
            if (valid && pending && (glitch_cnt != '1))
               glitch_cnt <= glitch_cnt + 1'b1;
         end else if (pending) begin
            cnt <= cnt + 8'd1;
         end

         if (commit) begin
            valid <= 1'b1;
            if (cand != {x_out, y_out}) begin
               {x_out, y_out} <= cand;
               change_pulse   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_settle_filter.sv
// Directed bench for settle_filter: a cycle-by-cycle vector table on the default
// instance, plus a saturating-counter sequence on a CNT_W=2 instance.
module tb_settle_filter;

   logic       clk = 1'b0;
   logic       rst, x_in, y_in;
   logic       x_out, y_out, valid, change_pulse;
   logic [7:0] glitch_cnt;

   logic       rst2, x2, y2;
   logic       x_out2, y_out2, valid2, change_pulse2;
   logic [1:0] glitch_cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   settle_filter #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
      .x_out(x_out), .y_out(y_out), .valid(valid),
      .change_pulse(change_pulse), .glitch_cnt(glitch_cnt)
   );

   settle_filter #(.STABLE_CYCLES(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst2), .x_in(x2), .y_in(y2),
      .x_out(x_out2), .y_out(y_out2), .valid(valid2),
      .change_pulse(change_pulse2), .glitch_cnt(glitch_cnt2)
   );

   typedef struct packed {
      logic       rst;
      logic       x;
      logic       y;
      logic [3:0] exp_flags;   // {x_out, y_out, valid, change_pulse}
      logic [7:0] exp_glitch;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic r, input logic x, input logic y,
                      input logic ex, input logic ey, input logic ev, input logic ep,
                      input logic [7:0] eg);
      vec_t v;
      v.rst = r; v.x = x; v.y = y;
      v.exp_flags = {ex, ey, ev, ep};
      v.exp_glitch = eg;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] got;
      logic [1:0] exp_g2;

      rst = 1'b1; x_in = 1'b0; y_in = 1'b0;
      rst2 = 1'b1; x2 = 1'b0; y2 = 1'b0;

      //    n  rst x y   xo yo v p  glitch
      add(2, 1, 0, 0,   0, 0, 0, 0, 0);  // reset
      add(3, 0, 0, 0,   0, 0, 0, 0, 0);  // first pair still settling
      add(3, 0, 0, 0,   0, 0, 1, 0, 0);  // valid on 4th edge, no pulse
      add(5, 0, 1, 0,   0, 0, 1, 0, 0);  // 00 -> 10 in flight
      add(1, 0, 1, 0,   1, 0, 1, 1, 0);  // committed on 6th edge
      add(4, 0, 1, 0,   1, 0, 1, 0, 0);
      add(2, 0, 1, 1,   1, 0, 1, 0, 0);  // 2-cycle y blip
      add(2, 0, 1, 0,   1, 0, 1, 0, 0);
      add(5, 0, 1, 0,   1, 0, 1, 0, 1);  // blip abandoned, revert silent
      add(5, 0, 0, 0,   1, 0, 1, 0, 1);  // back to 00
      add(1, 0, 0, 0,   0, 0, 1, 1, 1);
      add(1, 0, 0, 0,   0, 0, 1, 0, 1);
      add(3, 0, 0, 1,   0, 0, 1, 0, 1);  // hazard 01 for 3 cycles
      add(2, 0, 1, 1,   0, 0, 1, 0, 1);  // then 11
      add(3, 0, 1, 1,   0, 0, 1, 0, 2);
      add(1, 0, 1, 1,   1, 1, 1, 1, 2);  // straight to 11, no 01 published
      add(2, 0, 1, 1,   1, 1, 1, 0, 2);
      add(1, 1, 0, 0,   0, 0, 0, 0, 0);  // reset, re-establish 00
      add(3, 0, 0, 0,   0, 0, 0, 0, 0);
      add(2, 0, 0, 0,   0, 0, 1, 0, 0);
      add(5, 0, 1, 1,   0, 0, 1, 0, 0);  // 00 -> 11 pending, 3 samples seen
      add(1, 1, 1, 1,   0, 0, 0, 0, 0);  // reset discards it
      add(5, 0, 1, 1,   0, 0, 0, 0, 0);
      add(1, 0, 1, 1,   1, 1, 1, 1, 0);  // 6th edge after reset release
      add(1, 0, 1, 1,   1, 1, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; x_in = vecs[i].x; y_in = vecs[i].y;
         tick();
         got = {x_out, y_out, valid, change_pulse};
         n_cmp++;
         if (got !== vecs[i].exp_flags || glitch_cnt !== vecs[i].exp_glitch) begin
            n_bad++;
            $display("FAIL vec%0d: got xo/yo/v/p=%b glitch=%0d, want %b glitch=%0d",
                     i, got, glitch_cnt, vecs[i].exp_flags, vecs[i].exp_glitch);
         end
      end

      // Saturating glitch counter on the narrow instance.
      tick();
      n_cmp++;
      if ({x_out2, y_out2, valid2, change_pulse2, glitch_cnt2} !== 6'b0) begin
         n_bad++;
         $display("FAIL sat_reset: got %b%b%b%b g=%0d, want 0000 g=0",
                  x_out2, y_out2, valid2, change_pulse2, glitch_cnt2);
      end
      rst2 = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      for (int g = 1; g <= 5; g++) begin
         x2 = 1'b1;
         tick();
         x2 = 1'b0;
         for (int i = 0; i < 8; i++) tick();
         exp_g2 = (g >= 3) ? 2'd3 : 2'(g);
         n_cmp++;
         if (glitch_cnt2 !== exp_g2 || {x_out2, y_out2, valid2} !== 3'b001) begin
            n_bad++;
            $display("FAIL sat_glitch%0d: got g=%0d out=%b%b v=%b, want g=%0d out=00 v=1",
                     g, glitch_cnt2, x_out2, y_out2, valid2, exp_g2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/settle_filter.md
Name: settle_filter

Overview:
- Downstream consumer of the gate-level delay circuits in the basic library, such as the AND/OR/NOT network with unit gate delays.
- Samples the two asynchronous-ish combinational outputs x,y into the clocked domain.
- Publishes a new value of the pair only after it has held steady for STABLE_CYCLES consecutive clocks, so propagation hazards never reach downstream logic.
- Counts abandoned transitions (glitches) for debug.

Parameters:
- STABLE_CYCLES, 4, consecutive equal samples required before a pair is accepted; legal range 2..255.
- CNT_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- x_in  input  1  raw x from upstream combinational circuit
- y_in  input  1  raw y from upstream combinational circuit
- x_out  output  1  filtered, committed x
- y_out  output  1  filtered, committed y
- valid  output  1  high once a first stable pair has been confirmed after reset
- change_pulse  output  1  one-cycle strobe on the cycle the committed pair changes
- glitch_cnt  output  CNT_W  number of abandoned pending transitions, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a rising edge) clears all state:
  - s1, s2, cand all = 2'b00; cnt = 0.
  - x_out = y_out = 0; valid = 0; change_pulse = 0; glitch_cnt = 0.
- Reset mid-operation discards any pending transition. No commit or pulse occurs on the reset edge.
- Input stage: 2-flop synchronizer on the {x_in,y_in} pair, s1 <= {x_in,y_in}, s2 <= s1. The sample is s2.
- Candidate tracking, evaluated every edge when rst = 0:
  - If sample != cand: cand <= sample, cnt <= 1. If valid = 1 and cnt < STABLE_CYCLES, glitch_cnt increments (saturating at all-ones).
  - Else if cnt < STABLE_CYCLES: cnt <= cnt + 1.
  - Else (cnt == STABLE_CYCLES): cnt holds (saturated).
- Commit: on the edge where cnt goes to STABLE_CYCLES (sample == cand and cnt == STABLE_CYCLES-1):
  - valid <= 1; it then stays 1 until the next reset.
  - If cand != {x_out,y_out}: {x_out,y_out} <= cand and change_pulse <= 1.
  - change_pulse is 0 on every other edge.
- Latency: a pair change held at least STABLE_CYCLES+2 cycles appears on x_out/y_out, with change_pulse, at the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new value as edge 1.
- Changes shorter than STABLE_CYCLES samples are never published.
- Reverting to the committed value before confirmation is counted as a glitch. That revert itself restarts cnt, and when it completes it produces no change_pulse because cand == committed.
- Single-bit and two-bit changes are treated identically; x and y are always committed together.
- Counter widths: cnt is 8 bits; glitch_cnt is CNT_W bits and never wraps.

Test Plan (STABLE_CYCLES=4 unless noted):
- Reset, then x_in=y_in=0 held:
  - valid = 0 for 3 edges after rst drops, rises on the 4th edge.
  - x_out = y_out = 0, change_pulse never asserted, glitch_cnt = 0.
- After valid, set x_in=1, y_in=0, hold 10 cycles:
  - x_out = 1 exactly on the 6th edge after the change, with change_pulse high for one cycle.
  - y_out stays 0; glitch_cnt stays 0.
- From committed 10, pulse y_in=1 for 2 cycles, then return to 0:
  - x_out/y_out remain 1/0, no change_pulse, glitch_cnt = 1.
- Hazard sequence from committed 00: pair 01 for 3 cycles, then 11 held 8 cycles:
  - glitch_cnt = 1, outputs become 11 with a single change_pulse, no intermediate 01 on outputs.
- CNT_W=2: apply 5 separate 1-cycle glitches after valid:
  - glitch_cnt reads 1, 2, 3, 3, 3; outputs unchanged.
- Pending change (00->11) held 3 sampled cycles, then rst=1 for one edge with inputs still 11:
  - All outputs 0, valid 0 immediately after the reset edge.
  - With 11 still held, outputs become 11 and valid=1 on the 6th edge after rst drops.
